// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types and sizing helpers for the PRBS checker
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - Fibonacci LFSR x^N + x^(N-TAP) + 1, s[1] newest bit
// Shifts in either the external bit (self-seeding) or its own prediction (free-running).
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int N   = 7,
  parameter int TAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic use_pred,
  input  logic rx,
  output logic pred,
  output logic nonzero
);

  logic [N:1] s;

  assign pred    = s[N] ^ s[N-TAP];
  assign nonzero = |s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (shift_en) begin
      s <= {s[N-1:1], (use_pred ? pred : rx)};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS receiver with lock FSM and error counters
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int INV_PATTERN   = 0,
  parameter int POLY_LENGHT   = 7,
  parameter int POLY_TAP      = 1,
  parameter int LOCK_COUNT    = 32,
  parameter int WINDOW        = 128,
  parameter int UNLOCK_THRESH = 8,
  parameter int ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_in,
  input  logic                     data_valid,
  input  logic                     clear,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] bit_cnt,
  output logic [7:0]               lol_cnt
);

  localparam int   MW  = cnt_width(LOCK_COUNT);
  localparam int   WBW = cnt_width(WINDOW - 1);
  localparam int   WEW = cnt_width(UNLOCK_THRESH);
  localparam logic INV = 1'(INV_PATTERN != 0);

  prbs_state_t    state, state_nxt;
  logic           rx, pred, nonzero;
  logic           match, bit_err, lock_hit, unlock_hit, win_wrap, in_locked;
  logic [MW-1:0]  match_cnt;
  logic [WBW-1:0] win_bits;
  logic [WEW-1:0] win_errs, win_errs_inc;

  assign rx           = data_in ^ INV;
  assign in_locked    = (state == LOCKED);
  assign match        = (rx == pred) && nonzero;
  assign bit_err      = (rx != pred);
  assign win_errs_inc = win_errs + WEW'(1);
  assign win_wrap     = (win_bits == WBW'(WINDOW - 1));
  assign lock_hit     = !in_locked && data_valid && match && (match_cnt == MW'(LOCK_COUNT - 1));
  assign unlock_hit   = in_locked && data_valid && bit_err && (win_errs_inc >= WEW'(UNLOCK_THRESH));

  // While locked the LFSR free-runs on its own prediction so one flipped bit counts once.
  prbs_lfsr #(
    .N   (POLY_LENGHT),
    .TAP (POLY_TAP)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (data_valid),
    .use_pred (in_locked),
    .rx       (rx),
    .pred     (pred),
    .nonzero  (nonzero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (lock_hit)   state_nxt = LOCKED;
      LOCKED:  if (unlock_hit) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= data_valid && in_locked && bit_err;
      if (data_valid) begin
        if (!in_locked) begin
          match_cnt <= (match && !lock_hit) ? match_cnt + MW'(1) : '0;
          if (lock_hit) begin
            win_bits <= '0;
            win_errs <= '0;
          end
        end else begin
          match_cnt <= '0;
          win_bits  <= win_wrap ? '0 : win_bits + WBW'(1);
          if (win_wrap) begin
            win_errs <= '0;
          end else if (bit_err) begin
            win_errs <= win_errs_inc;
          end
        end
      end
    end
  end

  // Statistics counters: clear has priority over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      bit_cnt <= '0;
      lol_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
      bit_cnt <= '0;
      lol_cnt <= '0;
    end else begin
      if (data_valid && in_locked && (bit_cnt != '1)) begin
        bit_cnt <= bit_cnt + ERR_CNT_WIDTH'(1);
      end
      if (data_valid && in_locked && bit_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
      if (unlock_hit && (lol_cnt != 8'hFF)) begin
        lol_cnt <= lol_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard bench for prbs_checker (normal and inverted-pattern instances)
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic        data_valid = 1'b0;
  logic        clear = 1'b0;
  logic        data_in_n;
  logic        locked, err_pulse, locked_i, err_pulse_i;
  logic [31:0] err_cnt, bit_cnt, err_cnt_i, bit_cnt_i;
  logic [7:0]  lol_cnt, lol_cnt_i;

  int          pos_cnt = 0;
  int          n_checks = 0;
  int          n_errs = 0;
  int          sb[$];
  bit          saw_lock = 1'b0;
  logic [6:0]  h = '0;
  int          gen_idx = 0;

  assign data_in_n = ~data_in;

  prbs_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .bit_cnt    (bit_cnt),
    .lol_cnt    (lol_cnt)
  );

  prbs_checker #(.INV_PATTERN(1)) dut_inv (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in_n),
    .data_valid (data_valid),
    .clear      (clear),
    .locked     (locked_i),
    .err_pulse  (err_pulse_i),
    .err_cnt    (err_cnt_i),
    .bit_cnt    (bit_cnt_i),
    .lol_cnt    (lol_cnt_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  // Error-strobe monitor: each pulse must match the drive slot recorded by the stimulus.
  always @(negedge clk) begin
    if (locked || locked_i) saw_lock = 1'b1;
    if (err_pulse || err_pulse_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errs++;
        $display("FAIL err_pulse_unexpected: got pulse=%0b inv_pulse=%0b at slot %0d, required none",
                 err_pulse, err_pulse_i, pos_cnt - 1);
      end else begin
        int exp_slot;
        exp_slot = sb.pop_front();
        if (!(err_pulse && err_pulse_i && exp_slot == pos_cnt - 1)) begin
          n_errs++;
          $display("FAIL err_pulse_slot: got pulse=%0b inv_pulse=%0b slot=%0d, required both at slot %0d",
                   err_pulse, err_pulse_i, pos_cnt - 1, exp_slot);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic c);
    @(posedge clk);
    #1;
    data_in    = d;
    data_valid = v;
    clear      = c;
  endtask

  // PRBS7 stream b[k] = b[k-7] ^ b[k-6], first seven bits 1,0,0,0,0,0,0.
  task automatic next_bit(output logic b);
    if (gen_idx < 7) b = (gen_idx == 0);
    else             b = h[6] ^ h[5];
    h = {h[5:0], b};
    gen_idx++;
  endtask

  task automatic send_clean(input int n);
    logic b;
    repeat (n) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic send_err(input logic c);
    logic b;
    next_bit(b);
    step(~b, 1'b1, c);
    sb.push_back(pos_cnt);
  endtask

  task automatic idle;
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    clear      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    gen_idx = 0;
    h       = '0;
  endtask

  initial begin
    int vb;
    do_reset();
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("rst_bit_cnt", bit_cnt, 32'd0);
    chk("rst_lol_cnt", {24'd0, lol_cnt}, 32'd0);
    chk("rst_inv_locked", {31'd0, locked_i}, 32'd0);

    // All-zero stream never locks; the inverted instance sees all-ones.
    saw_lock = 1'b0;
    repeat (500) step(1'b0, 1'b1, 1'b0);
    idle();
    chk("zero_locked_ever", {31'd0, saw_lock}, 32'd0);
    chk("zero_err_cnt", err_cnt, 32'd0);
    chk("zero_bit_cnt", bit_cnt, 32'd0);

    // Clean PRBS7: matches start at bit 7, 32nd match is bit 38.
    do_reset();
    send_clean(38);
    idle();
    chk("lock_before_39", {31'd0, locked}, 32'd0);
    chk("inv_lock_before_39", {31'd0, locked_i}, 32'd0);
    send_clean(1);
    idle();
    chk("lock_at_39", {31'd0, locked}, 32'd1);
    chk("inv_lock_at_39", {31'd0, locked_i}, 32'd1);
    chk("lock_bit_cnt", bit_cnt, 32'd0);
    send_clean(2000);
    idle();
    chk("clean_err_cnt", err_cnt, 32'd0);
    chk("clean_bit_cnt", bit_cnt, 32'd2000);

    send_err(1'b0);
    send_clean(50);
    idle();
    chk("single_err_cnt", err_cnt, 32'd1);
    chk("single_bit_cnt", bit_cnt, 32'd2051);
    chk("single_locked", {31'd0, locked}, 32'd1);

    // Burst of errors inside one window: 7 keeps lock, the 8th drops it.
    repeat (7) send_err(1'b0);
    idle();
    chk("seven_err_locked", {31'd0, locked}, 32'd1);
    send_err(1'b0);
    idle();
    chk("lol_locked", {31'd0, locked}, 32'd0);
    chk("lol_inv_locked", {31'd0, locked_i}, 32'd0);
    chk("lol_cnt_1", {24'd0, lol_cnt}, 32'd1);
    chk("lol_err_cnt", err_cnt, 32'd9);
    chk("lol_bit_cnt", bit_cnt, 32'd2059);
    send_clean(31);
    idle();
    chk("relock_before_32", {31'd0, locked}, 32'd0);
    send_clean(1);
    idle();
    chk("relock_at_32", {31'd0, locked}, 32'd1);

    // Drive lol_cnt to saturation: 255 events, then one more.
    for (int i = 0; i < 254; i++) begin
      repeat (8) send_err(1'b0);
      send_clean(32);
    end
    idle();
    chk("lol_cnt_255", {24'd0, lol_cnt}, 32'd255);
    repeat (8) send_err(1'b0);
    send_clean(32);
    idle();
    chk("lol_cnt_sat", {24'd0, lol_cnt}, 32'd255);
    chk("sat_err_cnt", err_cnt, 32'd2049);
    chk("sat_bit_cnt", bit_cnt, 32'd4099);
    chk("sat_locked", {31'd0, locked}, 32'd1);

    // Clear coincident with an error: pulse still fires, counters read zero.
    send_err(1'b1);
    idle();
    chk("clr_err_cnt", err_cnt, 32'd0);
    chk("clr_bit_cnt", bit_cnt, 32'd0);
    chk("clr_lol_cnt", {24'd0, lol_cnt}, 32'd0);
    chk("clr_locked", {31'd0, locked}, 32'd1);
    send_clean(10);
    idle();
    chk("post_clr_bit_cnt", bit_cnt, 32'd10);

    // Asynchronous reset asserted mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_inv_locked", {31'd0, locked_i}, 32'd0);
    chk("arst_bit_cnt", bit_cnt, 32'd0);

    // Gapped valid: lock point counted in valid bits only; gap data is junk.
    do_reset();
    vb = 0;
    while (vb < 38) begin
      if ($urandom_range(0, 1) == 1) begin
        send_clean(1);
        vb++;
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    idle();
    chk("gap_lock_before_39", {31'd0, locked}, 32'd0);
    send_clean(1);
    idle();
    chk("gap_lock_at_39", {31'd0, locked}, 32'd1);
    repeat (20) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle();
    chk("freeze_bit_cnt", bit_cnt, 32'd0);
    chk("freeze_locked", {31'd0, locked}, 32'd1);
    vb = 0;
    while (vb < 100) begin
      if ($urandom_range(0, 1) == 1) begin
        send_clean(1);
        vb++;
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    idle();
    chk("gap_bit_cnt", bit_cnt, 32'd100);
    chk("gap_err_cnt", err_cnt, 32'd0);
    chk("gap_inv_bit_cnt", bit_cnt_i, 32'd100);

    repeat (3) idle();
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
